addsub_16bit_seq: RTL and testbench
===================================

ADDSUB_16BIT_SEQ -- requirements
Module: addsub_16bit_seq

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 start  input  1  request; sampled only while idle.
REQ-004 op  input  2  operation select: 00 ADD, 01 SUB, 10 PADDSB, 11 RED.
REQ-005 a  input  16  operand A, captured with start.
REQ-006 b  input  16  operand B, captured with start.
REQ-007 busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-008 done  output  1  one-cycle pulse; s is valid from this cycle.
REQ-009 s  output  16  result register.
REQ-010 ovfl  output  1  saturation occurred on the last ADD/SUB (present only with the REQ-028 macro).
REQ-011 zero  output  1  last result == 0x0000 (present only with the REQ-028 macro).

Function
REQ-012 States SHALL be IDLE, CALC, SAT, DONE; IDLE->CALC on start; CALC runs 4 cycles (nibble counter 0..3) ->SAT (1 cycle) ->DONE (1 cycle) ->IDLE.
REQ-013 start in IDLE SHALL capture op, a and b in that cycle (cycle 0); done SHALL assert in cycle 6; busy SHALL be high in cycles 1-6.
REQ-014 start while busy SHALL be ignored, and the captured operands SHALL NOT change.
REQ-015 start asserted in the DONE cycle SHALL be ignored; a new start is accepted from the following IDLE cycle, so back-to-back issue is every 7 cycles.
REQ-016 CALC SHALL process one 4-bit nibble per cycle, LSB first, with a registered inter-nibble carry; SUB SHALL use B inverted with carry-in 1.
REQ-017 ADD/SUB SHALL use 16-bit signed saturation: positive overflow gives 0x7FFF, negative overflow gives 0x8000, otherwise the exact sum.
REQ-018 PADDSB SHALL add each nibble independently (no inter-nibble carry), saturating to 0x7 or 0x8 per nibble on signed overflow.
REQ-019 RED SHALL compute (a[15:8]+a[7:0]) + (b[15:8]+b[7:0]) modulo 256 and sign-extend bit 7 into s[15:8], with no saturation.
REQ-020 s SHALL update only in the SAT cycle and hold until the next SAT cycle.
REQ-021 ovfl SHALL be 1 only if ADD/SUB saturated; it SHALL be 0 for PADDSB and RED and update with s.
REQ-022 zero SHALL equal (s == 0) and update with s.
REQ-023 op values are all legal; no illegal-op state exists.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, nibble counter 0, carry 0, busy 0, done 0, s 0x0000, ovfl 0, zero 1.
REQ-025 Reset mid-operation SHALL abort it; no done pulse follows, and s SHALL remain 0x0000 until a new operation completes.
REQ-026 After rst_n rises, the first start SHALL be accepted in the first clock edge at which it is sampled high.

Configuration
REQ-027 Core behaviour (s, busy, done) SHALL be identical with or without the REQ-028 macro.
REQ-028 Macro ADDSUB_SEQ_FLAGS_EN: when defined, the ovfl and zero ports and their registers SHALL exist per REQ-021/022; when undefined, the ports and their registers SHALL be absent.

Verification
REQ-029 ADD a=0x7FFF b=0x0001 -> done in cycle 6, s=0x7FFF, ovfl=1; ADD 0x1234+0x1111 -> s=0x2345, ovfl=0.
REQ-030 SUB a=0x8000 b=0x0001 -> s=0x8000, ovfl=1; SUB 0x0005-0x0005 -> s=0x0000, zero=1.
REQ-031 PADDSB a=0x7F18 b=0x1111 -> s=0x7029, ovfl=0.
REQ-032 RED a=0x0102 b=0x0304 -> s=0x000A; RED a=0x4040 b=0x0000 -> s=0xFF80.
REQ-033 start pulsed in cycles 2 and 6 of an ADD -> both ignored, exactly one done pulse, result unchanged.
REQ-034 rst_n low in cycle 3 of a SUB -> busy=0, s=0x0000, no done in the next 10 cycles; a subsequent ADD 1+1 -> s=0x0002.

Source files
------------

// File: rtl/addsub_16bit_seq.sv
// Sequential 16-bit add/sub/packed-nibble-add/byte-reduce unit, one nibble per CALC cycle.
// Optional ovfl/zero flag ports are enabled by defining ADDSUB_SEQ_FLAGS_EN.
module addsub_16bit_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] s
`ifdef ADDSUB_SEQ_FLAGS_EN
    ,
    output logic        ovfl,
    output logic        zero
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, SAT, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_PADDSB = 2'b10, OP_RED = 2'b11} op_t;

    state_t      state;
    op_t         op_r;
    logic [15:0] a_r, b_r, acc;
    logic [1:0]  cnt;
    logic        carry;

    logic [3:0]  na, nb, nb_eff, pnib, res_nib;
    logic [4:0]  nsum;
    logic        cin, pov, is_addsub, b15_eff, asov;
    logic [7:0]  red8;
    logic [15:0] result;

    always_comb begin
        na       = a_r[{cnt, 2'b00} +: 4];
        nb       = b_r[{cnt, 2'b00} +: 4];
        nb_eff   = (op_r == OP_SUB) ? ~nb : nb;
        cin      = (op_r == OP_PADDSB) ? 1'b0 : carry;
        nsum     = {1'b0, na} + {1'b0, nb_eff} + {4'b0000, cin};
        pov      = (na[3] == nb[3]) && (nsum[3] != na[3]);
        pnib     = pov ? (na[3] ? 4'h8 : 4'h7) : nsum[3:0];
        res_nib  = (op_r == OP_PADDSB) ? pnib : nsum[3:0];

        // Whole-word signed overflow judged from operand signs against the accumulated sum
        is_addsub = (op_r == OP_ADD) || (op_r == OP_SUB);
        b15_eff   = (op_r == OP_SUB) ? ~b_r[15] : b_r[15];
        asov      = is_addsub && (a_r[15] == b15_eff) && (acc[15] != a_r[15]);
        red8      = a_r[15:8] + a_r[7:0] + b_r[15:8] + b_r[7:0];

        result = acc;
        if (op_r == OP_RED)
            result = {{8{red8[7]}}, red8};
        else if (asov)
            result = a_r[15] ? 16'h8000 : 16'h7FFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_r  <= OP_ADD;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
`ifdef ADDSUB_SEQ_FLAGS_EN
            ovfl  <= 1'b0;
            zero  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op_t'(op);
                        a_r   <= a;
                        b_r   <= b;
                        cnt   <= '0;
                        carry <= (op == OP_SUB);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc[{cnt, 2'b00} +: 4] <= res_nib;
                    carry <= nsum[4];
                    cnt   <= cnt + 2'd1;
                    if (cnt == 2'd3)
                        state <= SAT;
                end
                SAT: begin
                    s     <= result;
`ifdef ADDSUB_SEQ_FLAGS_EN
                    ovfl  <= asov;
                    zero  <= (result == 16'h0000);
`endif
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    carry <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_16bit_seq.sv
// Directed self-checking bench for addsub_16bit_seq with an expected-result scoreboard.
module tb_addsub_16bit_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] s;
`ifdef ADDSUB_SEQ_FLAGS_EN
    logic        ovfl, zero;
`endif

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [16:0] sb_q[$];

    addsub_16bit_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s)
`ifdef ADDSUB_SEQ_FLAGS_EN
        ,
        .ovfl  (ovfl),
        .zero  (zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {ovfl, s}
    function automatic logic [16:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        int sum, nx, ny;
        logic [15:0] r;
        logic [7:0]  r8;
        logic        ov;
        r  = '0;
        ov = 1'b0;
        case (o)
            2'b00, 2'b01: begin
                sum = (o == 2'b00) ? (int'($signed(x)) + int'($signed(y)))
                                   : (int'($signed(x)) - int'($signed(y)));
                if (sum > 32767)       begin r = 16'h7FFF; ov = 1'b1; end
                else if (sum < -32768) begin r = 16'h8000; ov = 1'b1; end
                else                   r = sum[15:0];
            end
            2'b10: begin
                for (int i = 0; i < 4; i++) begin
                    nx  = int'($signed(x[i*4 +: 4]));
                    ny  = int'($signed(y[i*4 +: 4]));
                    sum = nx + ny;
                    if (sum > 7)       sum = 7;
                    else if (sum < -8) sum = -8;
                    r[i*4 +: 4] = sum[3:0];
                end
            end
            default: begin
                sum = int'(x[15:8]) + int'(x[7:0]) + int'(y[15:8]) + int'(y[7:0]);
                r8  = sum[7:0];
                r   = {{8{r8[7]}}, r8};
            end
        endcase
        return {ov, r};
    endfunction

    // Called at a negedge; issues start in the current cycle (cycle 0) and runs through cycle 7.
    task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] x,
                          input logic [15:0] y, input bit inject);
        int unsigned ndone;
        logic [16:0] exp;
        logic [15:0] prev_s;
        prev_s = s;
        ndone  = 0;
        exp    = '0;
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        sb_q.push_back(model(o, x, y));
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = inject && (k == 2 || k == 6);
            op    = 2'($urandom);
            a     = 16'($urandom);
            b     = 16'($urandom);
            if (done) begin
                ndone++;
                if (sb_q.size() > 0) exp = sb_q.pop_front();
                check({name, " s"}, 32'(s), 32'(exp[15:0]));
`ifdef ADDSUB_SEQ_FLAGS_EN
                check({name, " ovfl"}, 32'(ovfl), 32'(exp[16]));
                check({name, " zero"}, 32'(zero), 32'(exp[15:0] == 16'h0000));
`endif
            end
            if (k == 5) check({name, " s held"}, 32'(s), 32'(prev_s));
            if (k == 6) check({name, " done@6"}, 32'(done), 32'd1);
            if (k <= 6) check({name, " busy"}, 32'(busy), 32'd1);
            if (k == 7) begin
                check({name, " busy@7"}, 32'(busy), 32'd0);
                check({name, " s hold@7"}, 32'(s), 32'(exp[15:0]));
            end
        end
        start = 1'b0;
        check({name, " done count"}, ndone, 32'd1);
        sb_q.delete();
    endtask

    initial begin
        int unsigned nd;
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset s", 32'(s), 32'd0);
`ifdef ADDSUB_SEQ_FLAGS_EN
        check("reset ovfl", 32'(ovfl), 32'd0);
        check("reset zero", 32'(zero), 32'd1);
`endif
        rst_n = 1'b1;

        // Back-to-back ops, each issued in the IDLE cycle after the previous done
        run_op("add_sat", 2'b00, 16'h7FFF, 16'h0001, 1'b0);
        run_op("add",     2'b00, 16'h1234, 16'h1111, 1'b0);
        run_op("sub_sat", 2'b01, 16'h8000, 16'h0001, 1'b0);
        run_op("sub_zero",2'b01, 16'h0005, 16'h0005, 1'b0);
        run_op("paddsb",  2'b10, 16'h7F18, 16'h1111, 1'b0);
        run_op("red1",    2'b11, 16'h0102, 16'h0304, 1'b0);
        run_op("red2",    2'b11, 16'h4040, 16'h0000, 1'b0);
        run_op("sub_neg", 2'b01, 16'h0003, 16'h0007, 1'b0);
        run_op("paddsb_n",2'b10, 16'h8888, 16'h9F7F, 1'b0);
        run_op("add_inj", 2'b00, 16'h0F0F, 16'h00F1, 1'b1);

        // Abort a SUB with reset in cycle 3
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a     = 16'h5555;
        b     = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort s", 32'(s), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort no done", nd, 32'd0);
        check("abort s held", 32'(s), 32'd0);
        run_op("add_1p1", 2'b00, 16'h0001, 16'h0001, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
